user_led_pwm_axi: RTL and testbench

USER_LED_PWM_AXI -- requirements
Module: user_led_pwm_axi

---
 rtl/user_led_pwm_axi_if.sv | 38 +++
 rtl/user_led_pwm_axi.sv | 215 +++++++++++++++++++++
 tb/tb_user_led_pwm_axi.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/user_led_pwm_axi_if.sv
// AXI4-Lite bus bundle for the user LED PWM block.
// The master modport drives requests; the slave modport drives ready/response.
interface user_led_pwm_axi_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/user_led_pwm_axi.sv
// User LED controller with AXI4-Lite register access.
// Each LED is static, blinking or PWM-dimmed; blink and PWM share one
// prescaled tick. Register map (word index = addr[4:2]):
//   0 LED_EN, 1 MODE, 2 PRESCALE, 3 DUTY, 4 BLINK_HALF, 5 STATUS (RO).
module user_led_pwm_axi #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 5,
    parameter int NUM_LEDS             = 8,
    parameter int PWM_WIDTH            = 8,
    parameter int PRESCALE_WIDTH       = 16
) (
    input  logic                  s00_axi_aclk,
    input  logic                  s00_axi_aresetn,
    user_led_pwm_axi_if.slave     s00_axi,
    output logic [NUM_LEDS-1:0]   led_o
);

    // Byte-lane merge: strobed lanes take the new data, others keep the old.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return merged;
    endfunction

    // Bus handshake state
    logic                      awready_q, awready_d;
    logic                      bvalid_q,  bvalid_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q,  rvalid_d;
    logic [31:0]               rdata_q,   rdata_d;

    // Configuration registers
    logic [NUM_LEDS-1:0]       led_en_q,     led_en_d;
    logic [2*NUM_LEDS-1:0]     mode_q,       mode_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q,   prescale_d;
    logic [PWM_WIDTH-1:0]      duty_q,       duty_d;
    logic [15:0]               blink_half_q, blink_half_d;

    // Timebase counters
    logic [PRESCALE_WIDTH-1:0] presc_cnt_q,  presc_cnt_d;
    logic [PWM_WIDTH-1:0]      pwm_cnt_q,    pwm_cnt_d;
    logic [15:0]               blink_cnt_q,  blink_cnt_d;
    logic                      phase_q,      phase_d;
    logic [NUM_LEDS-1:0]       led_q,        led_d;

    logic [31:0] reg_view_s [8];
    logic [2:0]  wr_idx_s;
    logic [2:0]  rd_idx_s;
    logic        wr_fire_s;
    logic        rd_fire_s;
    logic        cnt_clr_s;
    logic        tick_s;
    logic        pwm_on_s;
    logic [31:0] wr_merged_s;
    logic        unused_s;

    assign wr_idx_s    = s00_axi.awaddr[4:2];
    assign rd_idx_s    = s00_axi.araddr[4:2];
    assign wr_fire_s   = awready_q & s00_axi.awvalid & s00_axi.wvalid;
    assign rd_fire_s   = arready_q & s00_axi.arvalid;
    // Reprogramming the timebase restarts it so the new period starts cleanly.
    assign cnt_clr_s   = wr_fire_s & ((wr_idx_s == 3'd2) | (wr_idx_s == 3'd4));
    assign tick_s      = (presc_cnt_q == prescale_q) & ~cnt_clr_s;
    assign pwm_on_s    = (pwm_cnt_q < duty_q);
    assign wr_merged_s = strb_merge(reg_view_s[wr_idx_s], s00_axi.wdata, s00_axi.wstrb);
    assign unused_s    = ^{s00_axi.awprot, s00_axi.arprot, s00_axi.awaddr[1:0],
                           s00_axi.araddr[1:0], wr_merged_s};

    // Zero-extended view of every word, shared by the read mux and the strobe merge.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            reg_view_s[i] = 32'd0;
        end
        reg_view_s[0][NUM_LEDS-1:0]       = led_en_q;
        reg_view_s[1][2*NUM_LEDS-1:0]     = mode_q;
        reg_view_s[2][PRESCALE_WIDTH-1:0] = prescale_q;
        reg_view_s[3][PWM_WIDTH-1:0]      = duty_q;
        reg_view_s[4][15:0]               = blink_half_q;
        reg_view_s[5][NUM_LEDS-1:0]       = led_q;
    end

    // Handshake next state; read and write channels are independent.
    always_comb begin
        awready_d = s00_axi.awvalid & s00_axi.wvalid & ~bvalid_q & ~awready_q;
        arready_d = s00_axi.arvalid & ~rvalid_q & ~arready_q;
        if (wr_fire_s) begin
            bvalid_d = 1'b1;
        end else if (s00_axi.bready) begin
            bvalid_d = 1'b0;
        end else begin
            bvalid_d = bvalid_q;
        end
        if (rd_fire_s) begin
            rvalid_d = 1'b1;
            rdata_d  = reg_view_s[rd_idx_s];
        end else if (s00_axi.rready) begin
            rvalid_d = 1'b0;
            rdata_d  = rdata_q;
        end else begin
            rvalid_d = rvalid_q;
            rdata_d  = rdata_q;
        end
    end

    // Register writes; STATUS and unmapped words are silently dropped.
    always_comb begin
        led_en_d     = led_en_q;
        mode_d       = mode_q;
        prescale_d   = prescale_q;
        duty_d       = duty_q;
        blink_half_d = blink_half_q;
        if (wr_fire_s) begin
            case (wr_idx_s)
                3'd0:    led_en_d     = wr_merged_s[NUM_LEDS-1:0];
                3'd1:    mode_d       = wr_merged_s[2*NUM_LEDS-1:0];
                3'd2:    prescale_d   = wr_merged_s[PRESCALE_WIDTH-1:0];
                3'd3:    duty_d       = wr_merged_s[PWM_WIDTH-1:0];
                3'd4:    blink_half_d = wr_merged_s[15:0];
                default: led_en_d     = led_en_q;
            endcase
        end else begin
            led_en_d = led_en_q;
        end
    end

    // Prescaler, PWM ramp and blink phase, all advanced by the shared tick.
    always_comb begin
        presc_cnt_d = presc_cnt_q;
        pwm_cnt_d   = pwm_cnt_q;
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (cnt_clr_s) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = '0;
            blink_cnt_d = 16'd0;
            phase_d     = 1'b0;
        end else if (tick_s) begin
            presc_cnt_d = '0;
            pwm_cnt_d   = pwm_cnt_q + PWM_WIDTH'(1);
            if (blink_cnt_q == blink_half_q) begin
                blink_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end else begin
            presc_cnt_d = presc_cnt_q + PRESCALE_WIDTH'(1);
        end
    end

    // Per-LED output select by mode.
    always_comb begin
        led_d = '0;
        for (int n = 0; n < NUM_LEDS; n++) begin
            case (mode_q[2*n +: 2])
                2'b00:   led_d[n] = led_en_q[n];
                2'b01:   led_d[n] = led_en_q[n] & phase_q;
                2'b10:   led_d[n] = led_en_q[n] & pwm_on_s;
                default: led_d[n] = 1'b0;
            endcase
        end
    end

    // State registers; reset drops any in-flight response.
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= 32'd0;
            led_en_q     <= '0;
            mode_q       <= '0;
            prescale_q   <= '0;
            duty_q       <= '0;
            blink_half_q <= 16'd0;
            presc_cnt_q  <= '0;
            pwm_cnt_q    <= '0;
            blink_cnt_q  <= 16'd0;
            phase_q      <= 1'b0;
            led_q        <= '0;
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            led_en_q     <= led_en_d;
            mode_q       <= mode_d;
            prescale_q   <= prescale_d;
            duty_q       <= duty_d;
            blink_half_q <= blink_half_d;
            presc_cnt_q  <= presc_cnt_d;
            pwm_cnt_q    <= pwm_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            led_q        <= led_d;
        end
    end

    assign s00_axi.awready = awready_q;
    assign s00_axi.wready  = awready_q;
    assign s00_axi.bvalid  = bvalid_q;
    assign s00_axi.bresp   = 2'b00;
    assign s00_axi.arready = arready_q;
    assign s00_axi.rvalid  = rvalid_q;
    assign s00_axi.rdata   = rdata_q;
    assign s00_axi.rresp   = 2'b00;
    assign led_o           = led_q;

endmodule

// File: tb/tb_user_led_pwm_axi.sv
// Directed bench for user_led_pwm_axi: register map, LED modes, PWM duty,
// blink period, back-pressure, same-cycle read/write and async reset.
module tb_user_led_pwm_axi;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] led;
    int         n_chk = 0;
    int         n_err = 0;
    int         cnt_a;
    int         cnt_b;
    logic [31:0] rdv;

    always #5 clk = ~clk;

    user_led_pwm_axi_if #(.ADDR_W(5), .DATA_W(32)) axi();

    user_led_pwm_axi #(
        .C_S00_AXI_DATA_WIDTH(32),
        .C_S00_AXI_ADDR_WIDTH(5),
        .NUM_LEDS(8),
        .PWM_WIDTH(8),
        .PRESCALE_WIDTH(16)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .s00_axi        (axi),
        .led_o          (led)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive until the requested responses arrive; valids drop after their handshake.
    task automatic run_txn(input bit do_wr, input bit do_rd, output logic [31:0] rd);
        bit need_b = do_wr;
        bit need_r = do_rd;
        bit aw_hs;
        bit ar_hs;
        rd = 32'd0;
        axi.bready = 1'b1;
        axi.rready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!need_b && !need_r) break;
            @(negedge clk);
            aw_hs = axi.awready && axi.awvalid;
            ar_hs = axi.arready && axi.arvalid;
            if (need_b && axi.bvalid) begin
                need_b = 1'b0;
                check_val("bresp", {30'd0, axi.bresp}, 32'd0);
            end
            if (need_r && axi.rvalid) begin
                need_r = 1'b0;
                rd = axi.rdata;
                check_val("rresp", {30'd0, axi.rresp}, 32'd0);
            end
            @(posedge clk);
            #1;
            if (aw_hs) begin
                axi.awvalid = 1'b0;
                axi.wvalid  = 1'b0;
            end
            if (ar_hs) axi.arvalid = 1'b0;
        end
        if (need_b || need_r) check_val("txn_timeout", {30'd0, need_b, need_r}, 32'd0);
    endtask

    task automatic drive_w(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] dummy;
        drive_w(addr, data, strb);
        run_txn(1'b1, 1'b0, dummy);
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        run_txn(1'b0, 1'b1, data);
    endtask

    // Wait for awready or arready, let the handshake edge pass, then drop valid.
    task automatic wait_hs(input string tag, input bit is_aw);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (is_aw ? axi.awready : axi.arready) begin
                seen = 1'b1;
                break;
            end
        end
        check_val(tag, {31'd0, seen}, 32'd1);
        @(posedge clk);
        #1;
        if (is_aw) begin
            axi.awvalid = 1'b0;
            axi.wvalid  = 1'b0;
        end else begin
            axi.arvalid = 1'b0;
        end
    endtask

    task automatic count_high(input int bit_i, output int cnt);
        cnt = 0;
        repeat (256) begin
            @(negedge clk);
            if (led[bit_i]) cnt++;
        end
    endtask

    // Clocks between two consecutive transitions of led[1]; 0 when fewer than two occur.
    task automatic measure_toggle(output int interval);
        logic prev;
        int   t0 = -1;
        interval = 0;
        @(negedge clk);
        prev = led[1];
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (led[1] !== prev) begin
                prev = led[1];
                if (t0 < 0) begin
                    t0 = c;
                end else begin
                    interval = c - t0;
                    break;
                end
            end
        end
    endtask

    initial begin
        axi.awaddr = 5'd0; axi.awprot = 3'd0; axi.awvalid = 1'b0;
        axi.wdata = 32'd0; axi.wstrb = 4'd0; axi.wvalid = 1'b0; axi.bready = 1'b0;
        axi.araddr = 5'd0; axi.arprot = 3'd0; axi.arvalid = 1'b0; axi.rready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_led", {24'd0, led}, 32'd0);
        check_val("rst_awready", {31'd0, axi.awready}, 32'd0);
        check_val("rst_bvalid", {31'd0, axi.bvalid}, 32'd0);
        check_val("rst_arready", {31'd0, axi.arready}, 32'd0);
        check_val("rst_rvalid", {31'd0, axi.rvalid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Register map write/read-back and unmapped address
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h04, 32'h2, 4'hF);
        wr(5'h08, 32'h3, 4'hF);
        wr(5'h0C, 32'h4, 4'hF);
        rd(5'h00, rdv); check_val("rb_led_en", rdv, 32'h1);
        rd(5'h04, rdv); check_val("rb_mode", rdv, 32'h2);
        rd(5'h08, rdv); check_val("rb_prescale", rdv, 32'h3);
        rd(5'h0C, rdv); check_val("rb_duty", rdv, 32'h4);
        rd(5'h18, rdv); check_val("rb_unmapped", rdv, 32'h0);
        wr(5'h10, 32'hFFFF_1234, 4'hF);
        rd(5'h10, rdv); check_val("rb_blink_mask", rdv, 32'h1234);

        // Static mode, STATUS, ignored writes, byte strobes, mode 11
        wr(5'h04, 32'h0, 4'hF);
        wr(5'h00, 32'hFF, 4'hF);
        check_val("static_led", {24'd0, led}, 32'hFF);
        rd(5'h14, rdv); check_val("status", rdv, 32'hFF);
        wr(5'h14, 32'h0, 4'hF);
        rd(5'h14, rdv); check_val("status_ro", rdv, 32'hFF);
        wr(5'h00, 32'h0, 4'h0);
        rd(5'h00, rdv); check_val("strb0_keep", rdv, 32'hFF);
        wr(5'h04, 32'h0000_FFFF, 4'b0010);
        rd(5'h04, rdv); check_val("strb_lane1", rdv, 32'hFF00);
        check_val("mode11_off", {24'd0, led}, 32'h0F);

        // PWM on LED 0
        wr(5'h04, 32'h2, 4'hF);
        wr(5'h00, 32'h1, 4'hF);
        wr(5'h0C, 32'd64, 4'hF);
        wr(5'h08, 32'd0, 4'hF);
        count_high(0, cnt_a); check_val("pwm_64", cnt_a, 32'd64);
        wr(5'h0C, 32'd0, 4'hF);
        count_high(0, cnt_a); check_val("pwm_0", cnt_a, 32'd0);
        wr(5'h0C, 32'd255, 4'hF);
        count_high(0, cnt_a); check_val("pwm_255", cnt_a, 32'd255);

        // Blink on LED 1: 10-clock tick, toggle every 5 ticks
        wr(5'h00, 32'h2, 4'hF);
        wr(5'h04, 32'h4, 4'hF);
        wr(5'h08, 32'd9, 4'hF);
        wr(5'h10, 32'd4, 4'hF);
        measure_toggle(cnt_a); check_val("blink_period_a", cnt_a, 32'd50);
        measure_toggle(cnt_a); check_val("blink_period_b", cnt_a, 32'd50);
        wr(5'h04, 32'h0, 4'hF);

        // Write back-pressure
        axi.bready = 1'b0;
        drive_w(5'h00, 32'h5A, 4'hF);
        wait_hs("bp_aw_hs", 1'b1);
        drive_w(5'h00, 32'h11, 4'hF);
        cnt_a = 0; cnt_b = 0;
        repeat (10) begin
            @(negedge clk);
            if (axi.bvalid) cnt_a++;
            if (axi.awready) cnt_b++;
        end
        check_val("bp_bvalid_held", cnt_a, 32'd10);
        check_val("bp_no_awready", cnt_b, 32'd0);
        axi.bready = 1'b1;
        @(posedge clk);
        #1;
        wr(5'h00, 32'h11, 4'hF);
        rd(5'h00, rdv); check_val("bp_second_wr", rdv, 32'h11);

        // Read back-pressure
        axi.rready = 1'b0;
        axi.araddr = 5'h00; axi.arvalid = 1'b1;
        wait_hs("bp_ar_hs", 1'b0);
        axi.araddr = 5'h08; axi.arvalid = 1'b1;
        cnt_a = 0; cnt_b = 0;
        repeat (10) begin
            @(negedge clk);
            if (axi.rvalid) cnt_a++;
            if (axi.arready) cnt_b++;
        end
        check_val("bp_rvalid_held", cnt_a, 32'd10);
        check_val("bp_no_arready", cnt_b, 32'd0);
        check_val("bp_rdata_held", axi.rdata, 32'h11);
        axi.rready = 1'b1;
        @(posedge clk);
        #1;
        run_txn(1'b0, 1'b1, rdv); check_val("bp_second_rd", rdv, 32'd9);

        // Same-cycle read and write of LED_EN returns the old value
        drive_w(5'h00, 32'h33, 4'hF);
        axi.araddr = 5'h00; axi.arvalid = 1'b1;
        run_txn(1'b1, 1'b1, rdv); check_val("sim_rd_old", rdv, 32'h11);
        rd(5'h00, rdv); check_val("sim_rd_new", rdv, 32'h33);

        // Reset while a write response is pending
        axi.bready = 1'b0;
        drive_w(5'h00, 32'hFF, 4'hF);
        wait_hs("rst_aw_hs", 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_val("pre_rst_bvalid", {31'd0, axi.bvalid}, 32'd1);
        check_val("pre_rst_led", {24'd0, led}, 32'hFF);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("async_bvalid", {31'd0, axi.bvalid}, 32'd0);
        check_val("async_led", {24'd0, led}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        axi.bready = 1'b1;
        cnt_a = 0;
        repeat (5) begin
            @(negedge clk);
            if (axi.bvalid) cnt_a++;
        end
        check_val("no_stale_b", cnt_a, 32'd0);
        for (int a = 0; a < 5; a++) begin
            rd(5'(a * 4), rdv);
            check_val("post_rst_reg", rdv, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
